packet_entry_ctrl: RTL and testbench

PACKET_ENTRY_CTRL -- requirements
Module: packet_entry_ctrl

---
 rtl/packet_entry_ctrl_pkg.sv | 21 ++
 rtl/packet_entry_ctrl_btn_edge.sv | 33 +++
 rtl/packet_entry_ctrl.sv | 134 +++++++++++++
 tb/tb_packet_entry_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/packet_entry_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// packet_entry_ctrl_pkg: shared router constants and entry FSM encoding
// Revision: 1.0
// ----------------------------------------------------------------------
package packet_entry_ctrl_pkg;

  localparam int DEFAULT_SIZE = 8;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_GET_DES   = 3'd1;
  localparam logic [STATE_W-1:0] ST_GET_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_GET_CHECK = 3'd3;
  localparam logic [STATE_W-1:0] ST_VERIFY    = 3'd4;
  localparam logic [STATE_W-1:0] ST_SEND      = 3'd5;

endpackage
`default_nettype wire

// File: rtl/packet_entry_ctrl_btn_edge.sv
`default_nettype none
// ----------------------------------------------------------------------
// btn_edge: rising-edge press detector, re-armed only by a release
// Revision: 1.0
// ----------------------------------------------------------------------
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;
  logic armed_q;

  // armed_q stays low out of reset until the button is seen released,
  // so a button held through reset release never counts as a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      if (!btn_i) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign press_o = btn_i & ~btn_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/packet_entry_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// packet_entry_ctrl: button-driven destination/data/checksum entry FSM
// Revision: 1.0
// ----------------------------------------------------------------------
module packet_entry_ctrl
  import packet_entry_ctrl_pkg::*;
#(
  parameter int size    = DEFAULT_SIZE,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enterBtn,
  input  logic [size-1:0] destnation,
  input  logic [size-1:0] data,
  input  logic [size:0]   checkSum,
  input  logic          pktReady,
  output logic          writeDes,
  output logic          writeData,
  output logic          writeCheck,
  output logic          pktValid,
  output logic          checkErr,
  output logic          busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             press;
  logic             timeout;
  logic             in_entry;
  logic [size:0]    sum;

  btn_edge u_btn_edge (
    .clk_i   (clock),
    .rst_ni  (reset),
    .btn_i   (enterBtn),
    .press_o (press)
  );

  // Carry out of the byte add is kept so it can match the wide checksum.
  assign sum      = {1'b0, destnation} + {1'b0, data};
  assign timeout  = (cnt_q == CNT_LAST);
  assign in_entry = (state_q == ST_GET_DES) || (state_q == ST_GET_DATA) ||
                    (state_q == ST_GET_CHECK);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    writeDes   = 1'b0;
    writeData  = 1'b0;
    writeCheck = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_GET_DES;
          err_d   = 1'b0;
        end
      end
      ST_GET_DES: begin
        if (press) begin
          writeDes = 1'b1;
          state_d  = ST_GET_DATA;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (press) begin
          writeData = 1'b1;
          state_d   = ST_GET_CHECK;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_CHECK: begin
        if (press) begin
          writeCheck = 1'b1;
          state_d    = ST_VERIFY;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_VERIFY: begin
        if (sum == checkSum) begin
          state_d = ST_SEND;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (pktReady) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Idle-cycle counter saturates rather than wrapping.
    if (press || (state_d != state_q) || !in_entry) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pktValid = (state_q == ST_SEND);
  assign busy     = (state_q != ST_IDLE);
  assign checkErr = err_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_entry_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_packet_entry_ctrl: directed self-checking bench for packet_entry_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------
module tb_packet_entry_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enterBtn;
  logic [7:0] destnation;
  logic [7:0] data;
  logic [8:0] checkSum;
  logic       pktReady;
  logic       writeDes, writeData, writeCheck, pktValid, checkErr, busy;

  int checks = 0;
  int errors = 0;
  int n_des = 0, n_data = 0, n_chk = 0, n_valid = 0;
  int b_des, b_data, b_chk, b_valid;

  packet_entry_ctrl #(.size(8), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .enterBtn   (enterBtn),
    .destnation (destnation),
    .data       (data),
    .checkSum   (checkSum),
    .pktReady   (pktReady),
    .writeDes   (writeDes),
    .writeData  (writeData),
    .writeCheck (writeCheck),
    .pktValid   (pktValid),
    .checkErr   (checkErr),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (writeDes)   n_des++;
    if (writeData)  n_data++;
    if (writeCheck) n_chk++;
    if (pktValid)   n_valid++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic snap();
    b_des = n_des; b_data = n_data; b_chk = n_chk; b_valid = n_valid;
  endtask

  // One clean press: button high for one cycle then released for one.
  task automatic press(input logic [2:0] exp, input string tag);
    enterBtn = 1'b1;
    #1;
    chk(tag, {29'd0, writeDes, writeData, writeCheck}, {29'd0, exp});
    tick();
    enterBtn = 1'b0;
    tick();
  endtask

  task automatic full_entry(input string tag);
    press(3'b000, {tag, "_idle"});
    press(3'b100, {tag, "_des"});
    press(3'b010, {tag, "_data"});
    press(3'b001, {tag, "_check"});
  endtask

  initial begin
    reset = 1'b0; enterBtn = 1'b0; pktReady = 1'b0;
    destnation = 8'h05; data = 8'h0A; checkSum = 9'h00F;
    tick(); tick();
    chk("reset_outputs", {26'd0, writeDes, writeData, writeCheck, pktValid, busy, checkErr}, 32'd0);
    reset = 1'b1;
    tick();

    // Nominal entry, router accepts in the second SEND cycle
    snap();
    full_entry("t1");
    chk("t1_send_valid", {31'd0, pktValid}, 32'd1);
    tick();
    pktReady = 1'b1;
    #1;
    chk("t1_valid_ready_cycle", {31'd0, pktValid}, 32'd1);
    tick();
    pktReady = 1'b0;
    chk("t1_back_idle", {30'd0, pktValid, busy}, 32'd0);
    chk("t1_strobe_counts", {8'd0, 8'(n_des - b_des), 8'(n_data - b_data), 8'(n_chk - b_chk)}, 32'h00010101);
    chk("t1_valid_cycles", 32'(n_valid - b_valid), 32'd2);
    chk("t1_checkerr", {31'd0, checkErr}, 32'd0);

    // Checksum with carry: 0xFF + 0x02 = 0x101
    destnation = 8'hFF; data = 8'h02; checkSum = 9'h101;
    full_entry("t2a");
    chk("t2_carry_send", {30'd0, pktValid, checkErr}, 32'h2);
    pktReady = 1'b1;
    tick();
    pktReady = 1'b0;
    chk("t2_carry_done", {31'd0, busy}, 32'd0);

    snap();
    checkSum = 9'h001;
    full_entry("t2b");
    chk("t2_mismatch_err", {30'd0, checkErr, busy}, 32'h2);
    chk("t2_mismatch_no_valid", 32'(n_valid - b_valid), 32'd0);

    // Timeout after 16 idle cycles in GET_DES; the press clears checkErr
    snap();
    press(3'b000, "t3_idle");
    chk("t3_err_cleared", {31'd0, checkErr}, 32'd0);
    repeat (14) tick();
    chk("t3_busy_before_limit", {31'd0, busy}, 32'd1);
    tick();
    chk("t3_idle_at_limit", {31'd0, busy}, 32'd0);
    chk("t3_no_strobes", 32'((n_des - b_des) + (n_data - b_data) + (n_chk - b_chk)), 32'd0);
    chk("t3_err_unchanged", {31'd0, checkErr}, 32'd0);

    // Held button is a single press
    destnation = 8'h05; data = 8'h0A; checkSum = 9'h00F;
    press(3'b000, "t4_idle");
    snap();
    enterBtn = 1'b1;
    #1;
    chk("t4_hold_first", {29'd0, writeDes, writeData, writeCheck}, 32'h4);
    repeat (50) tick();
    enterBtn = 1'b0;
    tick();
    chk("t4_hold_counts", {8'd0, 8'(n_des - b_des), 8'(n_data - b_data), 8'(n_chk - b_chk)}, 32'h00010000);
    chk("t4_hold_timed_out", {31'd0, busy}, 32'd0);

    // Press while in SEND is ignored
    full_entry("t4b");
    snap();
    press(3'b000, "t4b_send_press");
    chk("t4b_still_send", {31'd0, pktValid}, 32'd1);
    chk("t4b_no_strobes", 32'((n_des - b_des) + (n_data - b_data) + (n_chk - b_chk)), 32'd0);
    pktReady = 1'b1;
    tick();
    pktReady = 1'b0;
    chk("t4b_idle", {31'd0, busy}, 32'd0);

    // Reset mid-entry with the button held through release
    press(3'b000, "t5_idle");
    press(3'b100, "t5_des");
    enterBtn = 1'b1;
    #1;
    chk("t5_writedata", {29'd0, writeDes, writeData, writeCheck}, 32'h2);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_reset_async", {26'd0, writeDes, writeData, writeCheck, pktValid, busy, checkErr}, 32'd0);
    snap();
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("t5_held_no_press", {26'd0, writeDes, writeData, writeCheck, pktValid, busy, checkErr}, 32'd0);
    chk("t5_held_no_strobes", 32'((n_des - b_des) + (n_data - b_data) + (n_chk - b_chk)), 32'd0);
    enterBtn = 1'b0;
    tick();
    press(3'b000, "t5_repress_idle");
    chk("t5_repress_busy", {31'd0, busy}, 32'd1);
    press(3'b100, "t5_repress_des");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
